peak_result_streamer: RTL and testbench

PEAK_RESULT_STREAMER -- requirements
Module: peak_result_streamer

---
 rtl/peak_result_streamer.sv | 75 +++++++
 tb/tb_peak_result_streamer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/peak_result_streamer.sv
// peak_result_streamer: double-buffers per-pixel peak results and streams them one pixel per beat
module peak_result_streamer #(
  parameter int NP  = 16,
  parameter int PIX = 8,
  parameter int PW  = 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic              frame_done,
  input  logic [NP*PIX-1:0] result,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [NP-1:0]     out_data,
  output logic [PW-1:0]     out_pix,
  output logic              out_last,
  output logic [7:0]        out_frame,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_count
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state;
  logic [NP*PIX-1:0] pend_buf, act_buf;
  logic pend_full;
  logic [PW-1:0] idx;
  logic xfer, last, vacate;
  assign xfer = out_valid & out_ready;
  assign last = idx == PW'(PIX - 1);
  // pending empties on the idle hand-off or on a last-beat transfer that chains the next frame
  assign vacate = pend_full & ((state == IDLE) | (xfer & last));
  assign out_data = act_buf[idx*NP +: NP];
  assign out_pix = idx;
  assign out_last = out_valid & last;
  assign busy = pend_full | (state == STREAM);
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= IDLE;
      pend_buf <= '0;
      act_buf <= '0;
      pend_full <= 1'b0;
      idx <= '0;
      out_valid <= 1'b0;
      out_frame <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      if (frame_done && (!pend_full || vacate)) begin
        pend_buf <= result;
        pend_full <= 1'b1;
      end else if (vacate) pend_full <= 1'b0;
      if (frame_done && pend_full && !vacate) begin
        overflow <= 1'b1;
        if (drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      end
      if (state == IDLE) begin
        if (pend_full) begin
          act_buf <= pend_buf;
          state <= STREAM;
          idx <= '0;
          out_valid <= 1'b1;
        end
      end else if (xfer) begin
        if (last) begin
          out_frame <= out_frame + 8'd1;
          idx <= '0;
          if (pend_full) act_buf <= pend_buf;
          else begin
            state <= IDLE;
            out_valid <= 1'b0;
          end
        end else idx <= idx + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_peak_result_streamer.sv
// tb_peak_result_streamer: directed checks of peak_result_streamer
module tb_peak_result_streamer;
  logic clk = 0, res = 0, frame_done = 0, out_ready = 0;
  logic [127:0] result = '0;
  logic out_valid, out_last, busy, overflow;
  logic [15:0] out_data;
  logic [2:0] out_pix;
  logic [7:0] out_frame, drop_count;
  int checks = 0, failures = 0;
  int ef = 0;

  peak_result_streamer dut (
    .clk(clk), .res(res), .frame_done(frame_done), .result(result), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_pix(out_pix), .out_last(out_last),
    .out_frame(out_frame), .busy(busy), .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mk(input logic [15:0] base);
    logic [127:0] r;
    for (int p = 0; p < 8; p++) r[p*16 +: 16] = base + 16'(p);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_beat(input string tag, input logic [15:0] d, input int p, input int f);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " data"}, 32'(out_data), 32'(d));
    chk({tag, " pix"}, 32'(out_pix), 32'(p));
    chk({tag, " last"}, 32'(out_last), 32'(p == 7));
    chk({tag, " frame"}, 32'(out_frame), 32'(f & 255));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " valid"}, 32'(out_valid), 0);
    chk({tag, " data"}, 32'(out_data), 0);
    chk({tag, " pix"}, 32'(out_pix), 0);
    chk({tag, " last"}, 32'(out_last), 0);
    chk({tag, " frame"}, 32'(out_frame), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " ovf"}, 32'(overflow), 0);
    chk({tag, " drops"}, 32'(drop_count), 0);
  endtask

  task automatic pulse(input logic [15:0] base);
    result = mk(base);
    frame_done = 1;
    tick;
    frame_done = 0;
  endtask

  initial begin
    int p, c;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    res = 1;
    tick;
    // single frame, ready tied high
    out_ready = 1;
    pulse(16'h0100);
    chk("lat valid0", 32'(out_valid), 0);
    chk("lat busy", 32'(busy), 1);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk_beat("single", 16'h0100 + 16'(i), i, ef);
      tick;
    end
    ef++;
    chk("single end valid", 32'(out_valid), 0);
    chk("single end busy", 32'(busy), 0);
    chk("single end frame", 32'(out_frame), 32'(ef));
    // backpressure 1,0,0 pattern
    pulse(16'h0200);
    tick;
    p = 0;
    c = 0;
    while (p < 8 && c < 100) begin
      out_ready = (c % 3 == 0);
      chk_beat("bp", 16'h0200 + 16'(p), p, ef);
      tick;
      if (out_ready) p++;
      c++;
    end
    chk("bp done", 32'(p), 8);
    ef++;
    chk("bp end valid", 32'(out_valid), 0);
    // back-to-back frames
    out_ready = 1;
    pulse(16'h0300);
    tick;
    for (int i = 0; i < 16; i++) begin
      if (i == 2) begin
        result = mk(16'h0400);
        frame_done = 1;
      end
      chk_beat("b2b", i < 8 ? 16'h0300 + 16'(i) : 16'h0400 + 16'(i - 8), i % 8, ef + (i >= 8 ? 1 : 0));
      tick;
      frame_done = 0;
    end
    ef += 2;
    chk("b2b end valid", 32'(out_valid), 0);
    chk("b2b ovf", 32'(overflow), 0);
    chk("b2b frame", 32'(out_frame), 32'(ef));
    // drops under stall
    out_ready = 0;
    pulse(16'h0500);
    tick;
    pulse(16'h0600);
    pulse(16'h0700);
    chk("drop ovf", 32'(overflow), 1);
    chk("drop cnt1", 32'(drop_count), 1);
    chk("drop busy", 32'(busy), 1);
    chk_beat("drop hold", 16'h0500, 0, ef);
    frame_done = 1;
    repeat (300) tick;
    frame_done = 0;
    chk("drop sat", 32'(drop_count), 255);
    chk("drop ovf sticky", 32'(overflow), 1);
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk_beat("drain", i < 8 ? 16'h0500 + 16'(i) : 16'h0600 + 16'(i - 8), i % 8, ef + (i >= 8 ? 1 : 0));
      tick;
    end
    ef += 2;
    chk("drain end valid", 32'(out_valid), 0);
    // reset mid-frame at beat 3
    pulse(16'h0700);
    tick;
    repeat (3) tick;
    chk_beat("pre-rst", 16'h0703, 3, ef);
    #1 res = 0;
    #1 chk_zero("async rst");
    @(negedge clk);
    res = 1;
    tick;
    tick;
    chk("post rst valid", 32'(out_valid), 0);
    ef = 0;
    pulse(16'h0800);
    tick;
    for (int i = 0; i < 8; i++) begin
      chk_beat("post rst", 16'h0800 + 16'(i), i, ef);
      tick;
    end
    ef++;
    // frame_done on the pending-to-active edge
    result = mk(16'h0900);
    frame_done = 1;
    tick;
    result = mk(16'h0A00);
    tick;
    frame_done = 0;
    chk("coinc busy", 32'(busy), 1);
    for (int i = 0; i < 16; i++) begin
      chk_beat("coinc", i < 8 ? 16'h0900 + 16'(i) : 16'h0A00 + 16'(i - 8), i % 8, ef + (i >= 8 ? 1 : 0));
      tick;
    end
    ef += 2;
    chk("coinc ovf", 32'(overflow), 0);
    chk("coinc drops", 32'(drop_count), 0);
    chk("coinc end valid", 32'(out_valid), 0);
    chk("coinc frame", 32'(out_frame), 32'(ef));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
